// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared display definitions: segment glyphs (active-low {a,b,c,d,e,f,g}),
// controller FSM states and small sizing helpers.
package seven_seg_scan_ctrl_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Decimal digits needed for 2^w - 1, i.e. floor(w * log10(2)) + 1.
  function automatic int bcd_digits(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per clock, MSB
// first, DATA_W steps after start. done marks the clock of the final step.
module bin2bcd_seq
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    too_wide
);

  // One spare digit beyond both the displayable and the needed count, so the
  // "too wide for the display" slice always exists.
  localparam int NEED_DIGITS = bcd_digits(DATA_W);
  localparam int INT_DIGITS  = ((NEED_DIGITS > NUM_DIGITS) ? NEED_DIGITS : NUM_DIGITS) + 1;
  localparam int CNT_W       = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0]       shift_q;
  logic [4*INT_DIGITS-1:0] acc_q;
  logic [4*INT_DIGITS-1:0] acc_adj;
  logic [CNT_W-1:0]        step_q;
  logic                    busy_q;

  // NOTE: combinational blocks use blocking '=' with a default assigned first,
  // so every path drives acc_adj and no latch is inferred.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < INT_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      step_q  <= '0;
      shift_q <= '0;
      acc_q   <= '0;
    end else if (start) begin
      busy_q  <= 1'b1;
      step_q  <= '0;
      shift_q <= bin;
      acc_q   <= '0;
    end else if (busy_q) begin
      {acc_q, shift_q} <= {acc_adj, shift_q} << 1;
      step_q           <= step_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

  assign done     = busy_q && (step_q == LAST_STEP);
  assign bcd      = acc_q[4*NUM_DIGITS-1:0];
  assign too_wide = |acc_q[4*INT_DIGITS-1:4*NUM_DIGITS];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment controller: accepts a binary value, converts it
// to decimal with sign/overflow handling, and scans the digits continuously.
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 5,
  parameter int DATA_W     = 16,
  parameter int REFRESH_W  = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_signed,
  input  logic [NUM_DIGITS-1:0] in_dp,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg,
  output logic                  dp_n
);

  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam int RC_W  = REFRESH_W + SEL_W;
  localparam logic [SEL_W-1:0] TOP_SEL = SEL_W'(NUM_DIGITS - 1);
  localparam logic [RC_W-1:0]  RC_LAST = {TOP_SEL, {REFRESH_W{1'b1}}};

  state_t                  state_q;
  logic                    ready_q;
  logic                    neg_q;
  logic [NUM_DIGITS-1:0]   cap_dp_q;
  logic [6:0]              disp_seg_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   disp_dp_q;
  logic [RC_W-1:0]         rc_q;

  logic                    capture;
  logic                    in_neg;
  logic [DATA_W-1:0]       magnitude;
  logic                    conv_done;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic                    too_wide;
  logic [SEL_W-1:0]        msd;
  logic                    overflow;
  logic [6:0]              next_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   next_dp;
  logic [SEL_W-1:0]        scan_idx;

  assign capture   = (state_q == IDLE) && in_valid;
  assign in_neg    = in_signed && in_data[DATA_W-1];
  // Negating -2^(DATA_W-1) wraps back to itself, which read unsigned is the
  // correct magnitude.
  assign magnitude = in_neg ? (~in_data + DATA_W'(1)) : in_data;

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (capture),
    .bin      (magnitude),
    .done     (conv_done),
    .bcd      (bcd),
    .too_wide (too_wide)
  );

  // Glyphs to commit: digits up to the most significant nonzero one, a minus
  // just left of it for negatives, blanks beyond; overflow is all minus.
  always_comb begin
    msd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = SEL_W'(i);
    end
    overflow = too_wide || (neg_q && (msd == TOP_SEL));
    next_dp  = overflow ? '0 : cap_dp_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      next_seg[i] = SEG_BLANK;
      if (overflow)                                    next_seg[i] = SEG_MINUS;
      else if (i <= int'(msd))                         next_seg[i] = seg_of(bcd[4*i +: 4]);
      else if (neg_q && (i == int'(msd) + 1))          next_seg[i] = SEG_MINUS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      neg_q     <= 1'b0;
      cap_dp_q  <= '0;
      disp_dp_q <= '0;
      // NOTE: the display registers are state the outputs decode directly,
      // so every entry is reset, not just the control bits.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        disp_seg_q[i] <= (i == 0) ? SEG_0 : SEG_BLANK;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            neg_q    <= in_neg;
            cap_dp_q <= in_dp;
            state_q  <= CONV;
            ready_q  <= 1'b0;
          end
        end
        CONV: begin
          if (conv_done) state_q <= COMMIT;
        end
        COMMIT: begin
          disp_seg_q <= next_seg;
          disp_dp_q  <= next_dp;
          state_q    <= IDLE;
          ready_q    <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Free-running refresh counter; wraps early when NUM_DIGITS is not a
  // power of two so unused scan codes never appear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rc_q <= '0;
    else if (rc_q == RC_LAST) rc_q <= '0;
    else                     rc_q <= rc_q + 1'b1;
  end

  assign scan_idx = rc_q[RC_W-1 -: SEL_W];
  assign in_ready = ready_q;

  always_comb begin
    anode = '1;
    seg   = SEG_BLANK;
    dp_n  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == SEL_W'(i)) begin
        anode[i] = 1'b0;
        seg      = disp_seg_q[i];
        dp_n     = ~disp_dp_q[i];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench: an arithmetic model of the displayed number is compared
// with the scanned outputs every cycle, plus literal checks of key cases.
module tb_seven_seg_scan_ctrl;

  localparam int NUM_DIGITS = 5;
  localparam int DATA_W     = 16;
  localparam int REFRESH_W  = 2;
  localparam int DWELL      = 1 << REFRESH_W;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b1111110;
  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100;
  localparam logic [6:0] G9 = 7'b0000100;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data = '0;
  logic                  in_signed = 1'b0;
  logic [NUM_DIGITS-1:0] in_dp = '0;
  logic [NUM_DIGITS-1:0] anode;
  logic [6:0]            seg;
  logic                  dp_n;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Model: displayed value as a signed integer, scan position, busy countdown.
  int                    m_cnt  = 0;
  int                    m_busy = 0;
  int                    m_val  = 0;
  int                    p_val  = 0;
  logic [NUM_DIGITS-1:0] m_dp   = '0;
  logic [NUM_DIGITS-1:0] p_dp   = '0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS (NUM_DIGITS),
    .DATA_W     (DATA_W),
    .REFRESH_W  (REFRESH_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .in_dp     (in_dp),
    .anode     (anode),
    .seg       (seg),
    .dp_n      (dp_n)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic int value_of(input logic [DATA_W-1:0] d, input logic s);
    int v = int'(d);
    if (s && v >= (1 << (DATA_W - 1))) v = v - (1 << DATA_W);
    return v;
  endfunction

  function automatic int ndigits(input int mag);
    int n = 1;
    while (mag >= 10) begin
      mag = mag / 10;
      n++;
    end
    return n;
  endfunction

  function automatic bit overflowed(input int v);
    int nd = ndigits((v < 0) ? -v : v);
    return (nd > NUM_DIGITS) || (v < 0 && nd == NUM_DIGITS);
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int i);
    int mag = (v < 0) ? -v : v;
    int nd  = ndigits(mag);
    if (overflowed(v)) return MINUS;
    if (i < nd) begin
      for (int k = 0; k < i; k++) mag = mag / 10;
      return glyph(mag % 10);
    end
    if (v < 0 && i == nd) return MINUS;
    return BLANK;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_busy <= 0;
      m_val  <= 0;
      m_dp   <= '0;
    end else begin
      m_cnt <= (m_cnt + 1) % (NUM_DIGITS * DWELL);
      if (m_busy == 0) begin
        if (in_valid) begin
          p_val  <= value_of(in_data, in_signed);
          p_dp   <= in_dp;
          m_busy <= DATA_W + 1;
        end
      end else begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_val <= p_val;
          m_dp  <= p_dp;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [NUM_DIGITS-1:0] ea;
      int idx;
      idx = m_cnt / DWELL;
      ea = '1;
      ea[idx] = 1'b0;
      check("in_ready", in_ready, m_busy == 0);
      check("anode", anode, ea);
      check("seg", seg, exp_seg(m_val, idx));
      check("dp_n", dp_n, !(m_dp[idx] && !overflowed(m_val)));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready still %b after %0d cycles", in_ready, n);
    end
  endtask

  // Offer one value at posedge+2; returns 2 time units after the capture edge.
  task automatic send(input logic [DATA_W-1:0] d, input logic s, input logic [NUM_DIGITS-1:0] dp);
    wait_ready();
    in_data   = d;
    in_signed = s;
    in_dp     = dp;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic read_digit(input int i, output logic [6:0] s, output logic d);
    int n = 0;
    logic [NUM_DIGITS-1:0] a;
    a = '1;
    a[i] = 1'b0;
    @(negedge clk);
    while (anode !== a && n < 3 * NUM_DIGITS * DWELL) begin
      @(negedge clk);
      n++;
    end
    if (anode !== a) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: digit %0d never selected, anode=%b", i, anode);
    end
    s = seg;
    d = dp_n;
  endtask

  task automatic check_display(input string tag, input logic [6:0] e4, input logic [6:0] e3,
                               input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0,
                               input logic [NUM_DIGITS-1:0] edpn);
    logic [6:0] e [NUM_DIGITS];
    logic [6:0] s;
    logic       d;
    e = '{e0, e1, e2, e3, e4};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      read_digit(i, s, d);
      check($sformatf("%s_seg%0d", tag, i), s, e[i]);
      check($sformatf("%s_dpn%0d", tag, i), d, edpn[i]);
    end
    step();
  endtask

  initial begin
    int n;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    cmp_en = 1'b1;
    check("rst_ready", in_ready, 1'b1);
    check("rst_anode", anode, 5'b11110);
    check("rst_seg", seg, 7'b0000001);
    check("rst_dpn", dp_n, 1'b1);
    rst_n = 1'b1;
    check_display("reset", BLANK, BLANK, BLANK, BLANK, G0, 5'b11111);

    // 12345 unsigned: 17 busy cycles, then 1,2,3,4,5 with dp on digit 2.
    send(16'd12345, 1'b0, 5'b00100);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
    end
    check("busy_cycles", n, 17);
    step();
    check_display("u12345", G1, G2, G3, G4, G5, 5'b11011);

    send(16'hFF85, 1'b1, 5'b00000);
    wait_ready();
    check_display("neg123", BLANK, MINUS, G1, G2, G3, 5'b11111);

    send(16'h8000, 1'b1, 5'b11111);
    wait_ready();
    check_display("ovf", MINUS, MINUS, MINUS, MINUS, MINUS, 5'b11111);

    send(16'hD8F1, 1'b1, 5'b00001);
    wait_ready();
    check_display("neg9999", MINUS, G9, G9, G9, G9, 5'b11110);

    // in_valid held through a conversion with changing data.
    wait_ready();
    in_data   = 16'd777;
    in_signed = 1'b0;
    in_dp     = '0;
    in_valid  = 1'b1;
    step();
    for (int k = 0; k < 40; k++) begin
      if (in_ready === 1'b1) begin
        in_data   = 16'd4242;
        in_signed = 1'b0;
        in_dp     = '0;
        break;
      end
      in_data   = 16'($urandom);
      in_signed = 1'($urandom);
      in_dp     = 5'($urandom);
      step();
    end
    step();
    in_valid = 1'b0;
    wait_ready();
    check_display("held", BLANK, G4, G2, G4, G2, 5'b11111);

    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 3) == 0);
      in_signed = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       in_data = 16'($urandom_range(0, 99));
        1:       in_data = 16'h8000;
        2:       in_data = 16'hD8F0;
        3:       in_data = 16'hD8F1;
        default: in_data = 16'($urandom);
      endcase
      in_dp = 5'($urandom);
      step();
    end
    in_valid = 1'b0;
    wait_ready();

    // Reset during the 8th CONV cycle discards the conversion.
    send(16'd31415, 1'b0, 5'b00000);
    wait_ready();
    send(16'd999, 1'b0, 5'b00010);
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_ready", in_ready, 1'b1);
    check("abort_anode", anode, 5'b11110);
    check("abort_seg", seg, 7'b0000001);
    check("abort_dpn", dp_n, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (40) step();
    check_display("abort", BLANK, BLANK, BLANK, BLANK, G0, 5'b11111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
